uart_bus_master: RTL and testbench
==================================

# uart_bus_master

Bus initiator for the UART register interface: it drives the 2-bit address, 8-bit data, write-enable, bus clock and strobe lines that the UART slave samples, and returns read data and ack status. It lets on-chip logic issue register reads and writes to the UART that the external RPi host otherwise performs. A valid/ready command port on the `clk` domain feeds it. It generates `bus_clk` by division, so one system clock drives the whole block.

## Interface
- `CLK_DIV`, default 4: `clk` cycles per `bus_clk` phase (low setup, high, low hold); ≥1.
- `ACK_TIMEOUT`, default 16: maximum `clk` cycles spent in WAIT_ACK; ≥1.
- `USE_ACK`, default 1: 0 means ignore `bus_ack` and never flag an error.

Ports:
- `clk` in 1: system clock (12 MHz reference).
- `reset` in 1: synchronous, active-high.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: the block accepts a command when `cmd_valid & cmd_ready` at a rising edge.
- `cmd_we` in 1: 1 for write, 0 for read.
- `cmd_addr` in 2: register address.
- `cmd_wdata` in 8: write data.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out 8: read data; 0 for writes.
- `rsp_err` out 1: ack timeout; valid with `rsp_valid`.
- `bus_addr` out 2, `bus_data_out` out 8, `bus_we` out 1: bus address, data and direction.
- `bus_data_in` in 8: read data from the slave.
- `bus_clk` out 1: generated bus clock.
- `bus_stb` out 1: chip select.
- `bus_ack` in 1: slave ack; asynchronous; passes through a 2-flop synchronizer.

## Operation
- FSM states: IDLE, SETUP, HIGH, HOLD, WAIT_ACK, DONE. A phase counter counts 1..CLK_DIV; a timeout counter counts 1..ACK_TIMEOUT.
- `cmd_ready` = (state==IDLE) & ~reset.
- IDLE, on accept:
  - Latch the command.
  - Drive `bus_addr`, `bus_we`, and `bus_data_out` (cmd_wdata for writes, 0 for reads).
  - Set `bus_stb` to 1 and `bus_clk` to 0.
  - Go to SETUP.
- SETUP: CLK_DIV cycles with `bus_clk`=0, then go to HIGH.
- HIGH: CLK_DIV cycles with `bus_clk`=1. For reads, capture `bus_data_in` on the edge that ends the last HIGH cycle. Then go to HOLD.
- HOLD: CLK_DIV cycles with `bus_clk`=0 and `bus_stb` still 1. On exit:
  - USE_ACK=0, or `ack_seen` set: go to DONE with err=0.
  - Otherwise: go to WAIT_ACK.
- `ack_seen`: sticky flag. It sets when the synchronized ack is 1 in any of SETUP, HIGH, HOLD or WAIT_ACK, and clears in IDLE.
- WAIT_ACK:
  - Synchronized ack = 1: go to DONE with err=0 next cycle.
  - ACK_TIMEOUT cycles without ack: go to DONE with err=1.
- DONE, one cycle:
  - `rsp_valid`=1.
  - `bus_stb`=0, `bus_we`=0, `bus_clk`=0.
  - `rsp_rdata` and `rsp_err` are valid.
  - Next state is IDLE.
- `rsp_rdata` and `rsp_err` hold until the next DONE.
- The block accepts no new command while busy. `cmd_*` inputs are ignored outside IDLE.
- Reset, including mid-transaction: abort immediately with no `rsp_valid`.

## Timing
- All bus and rsp outputs are registered.
- Reset values: `bus_addr`=0, `bus_data_out`=0, `bus_we`=0, `bus_clk`=0, `bus_stb`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `cmd_ready`=0. The synchronizer and `ack_seen` also clear.
- Cycle numbering: accept edge ends cycle 0.
  - SETUP: cycles 1..D.
  - HIGH (`bus_clk`=1): cycles D+1..2D.
  - HOLD: cycles 2D+1..3D.
  - DONE: cycle 3D+1 when the ack was seen early.
  - `cmd_ready` returns in cycle 3D+2.
  - Defaults (D=4): `bus_stb` high in cycles 1..12, `bus_clk` high in 5..8, `rsp_valid` in 13, ready in 14.
- Timeout path: WAIT_ACK occupies cycles 3D+1..3D+T and DONE is 3D+T+1 (29 for defaults).
- Ack latency: a raw ack rising in cycle k is visible to the FSM in cycle k+2.

## Structure
- Package `uart_bus_pkg` holds:
  - the FSM state enum;
  - address constants for the UART registers;
  - the counter width function, $clog2 of the parameters.
- Sub-module `sync2`: a generic 2-flop synchronizer, used for `bus_ack`.
- Top: `uart_bus_master`, with the FSM, counters and capture registers inline.

## Test plan
- **Write, early ack.** Write addr=0, wdata=0x41; slave model raises ack in cycle 5.
  - `bus_stb`=1 in cycles 1..12, `bus_clk`=1 in 5..8, `bus_we`=1, `bus_data_out`=0x41.
  - `rsp_valid` in 13 with err=0; `cmd_ready` in 14.
- **Read, early ack.** Read addr=1; slave drives 0x5A during HIGH with early ack → `rsp_rdata`=0x5A, err=0, `bus_we`=0 throughout.
- **No ack.** `bus_ack` held 0 → WAIT_ACK cycles 13..28, `rsp_valid` and `rsp_err`=1 in cycle 29, `rsp_rdata`=0.
- **Late ack.** Raw ack rises in cycle 18 → `rsp_valid` in 21 with err=0.
- **Busy, then back-to-back.** `cmd_valid` held continuously with two different commands → the block ignores the second until `cmd_ready` in cycle 14 and accepts it then. Second `bus_stb` spans cycles 15..26.
- **Reset mid-HIGH.** `reset` pulsed in cycle 6 → `bus_stb`=0 and `bus_clk`=0 from cycle 7, no `rsp_valid`, `cmd_ready`=1 the cycle after reset drops.

Source files
------------

// File: rtl/uart_bus_pkg.sv
// Shared types and constants for the UART register-bus initiator.
package uart_bus_pkg;

  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DATA_W = 8;

  // UART register map as seen on the 2-bit bus address
  localparam logic [ADDR_W-1:0] UART_REG_DATA   = 2'd0;
  localparam logic [ADDR_W-1:0] UART_REG_STATUS = 2'd1;
  localparam logic [ADDR_W-1:0] UART_REG_CTRL   = 2'd2;
  localparam logic [ADDR_W-1:0] UART_REG_BAUD   = 2'd3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    HIGH     = 3'd2,
    HOLD     = 3'd3,
    WAIT_ACK = 3'd4,
    DONE     = 3'd5
  } bus_state_e;

  // Command payload as presented on the valid/ready port
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_cmd_t;

  // Width of a counter that must hold values 1..max_count
  function automatic int unsigned cnt_width(input int unsigned max_count);
    if (max_count < 2) return 1;
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/uart_bus_master_sync2.sv
// Generic two-flop synchronizer for asynchronous single-bit or vector inputs.
module sync2 #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two back-to-back flops; first stage may go metastable
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_bus_master.sv
// Register-bus initiator for the UART slave: runs one setup/high/hold bus
// cycle per accepted command, waits for ack, and returns read data and status.
module uart_bus_master
  import uart_bus_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter bit          USE_ACK     = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_data_out,
  output logic              bus_we,
  input  logic [DATA_W-1:0] bus_data_in,
  output logic              bus_clk,
  output logic              bus_stb,
  input  logic              bus_ack
);

  localparam int unsigned PW = cnt_width(CLK_DIV);
  localparam int unsigned TW = cnt_width(ACK_TIMEOUT);

  bus_state_e        state, state_d;
  logic [PW-1:0]     phase_cnt, phase_d;
  logic [TW-1:0]     to_cnt, to_d;
  logic              ack_sync;
  logic              ack_seen, ack_seen_d;
  logic [DATA_W-1:0] rd_data, rd_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] dout_d;
  logic              we_d, bclk_d, stb_d;
  logic              rsp_valid_d, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_d;
  logic              phase_last, to_last;
  logic              finish, finish_err;
  bus_cmd_t          cmd_in;

  assign cmd_in     = {cmd_we, cmd_addr, cmd_wdata};
  assign cmd_ready  = (state == IDLE) & ~reset;
  assign phase_last = (phase_cnt == PW'(CLK_DIV));
  assign to_last    = (to_cnt == TW'(ACK_TIMEOUT));

  sync2 #(.W(1)) u_ack_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus_ack),
    .q     (ack_sync)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Next-state and next-output logic for the bus cycle sequencer
  always_comb begin
    state_d     = state;
    phase_d     = phase_cnt;
    to_d        = to_cnt;
    ack_seen_d  = ack_seen;
    rd_d        = rd_data;
    addr_d      = bus_addr;
    dout_d      = bus_data_out;
    we_d        = bus_we;
    bclk_d      = bus_clk;
    stb_d       = bus_stb;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    finish      = 1'b0;
    finish_err  = 1'b0;

    if (ack_sync && (state inside {SETUP, HIGH, HOLD, WAIT_ACK})) ack_seen_d = 1'b1;

    case (state)
      IDLE: begin
        ack_seen_d = 1'b0;
        if (cmd_valid && cmd_ready) begin
          addr_d  = cmd_in.addr;
          we_d    = cmd_in.we;
          dout_d  = cmd_in.we ? cmd_in.wdata : '0;
          stb_d   = 1'b1;
          bclk_d  = 1'b0;
          phase_d = PW'(1);
          rd_d    = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (phase_last) begin
          phase_d = PW'(1);
          bclk_d  = 1'b1;
          state_d = HIGH;
        end else begin
          phase_d = phase_cnt + PW'(1);
        end
      end
      HIGH: begin
        if (phase_last) begin
          phase_d = PW'(1);
          bclk_d  = 1'b0;
          if (!bus_we) rd_d = bus_data_in;
          state_d = HOLD;
        end else begin
          phase_d = phase_cnt + PW'(1);
        end
      end
      HOLD: begin
        if (phase_last) begin
          // An ack arriving on the last hold cycle still counts as early
          if (!USE_ACK || ack_seen || ack_sync) begin
            finish = 1'b1;
          end else begin
            to_d    = TW'(1);
            state_d = WAIT_ACK;
          end
        end else begin
          phase_d = phase_cnt + PW'(1);
        end
      end
      WAIT_ACK: begin
        if (ack_sync) begin
          finish = 1'b1;
        end else if (to_last) begin
          finish     = 1'b1;
          finish_err = 1'b1;
        end else begin
          to_d = to_cnt + TW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (finish) begin
      state_d     = DONE;
      rsp_valid_d = 1'b1;
      rsp_err_d   = finish_err;
      rsp_rdata_d = bus_we ? '0 : rd_data;
      stb_d       = 1'b0;
      we_d        = 1'b0;
      bclk_d      = 1'b0;
    end
  end

  // Registered bus, response, counter and capture state
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_cnt    <= '0;
      to_cnt       <= '0;
      ack_seen     <= 1'b0;
      rd_data      <= '0;
      bus_addr     <= '0;
      bus_data_out <= '0;
      bus_we       <= 1'b0;
      bus_clk      <= 1'b0;
      bus_stb      <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
    end else begin
      phase_cnt    <= phase_d;
      to_cnt       <= to_d;
      ack_seen     <= ack_seen_d;
      rd_data      <= rd_d;
      bus_addr     <= addr_d;
      bus_data_out <= dout_d;
      bus_we       <= we_d;
      bus_clk      <= bclk_d;
      bus_stb      <= stb_d;
      rsp_valid    <= rsp_valid_d;
      rsp_rdata    <= rsp_rdata_d;
      rsp_err      <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed plus randomized bench for uart_bus_master with a cycle-schedule model.
module tb_uart_bus_master;

  localparam int D = 4;
  localparam int T = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready, cmd_we;
  logic [1:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid, rsp_err;
  logic [7:0] rsp_rdata;
  logic [1:0] bus_addr;
  logic [7:0] bus_data_out, bus_data_in;
  logic       bus_we, bus_clk, bus_stb, bus_ack;

  int checks = 0;
  int errors = 0;

  uart_bus_master #(
    .CLK_DIV     (D),
    .ACK_TIMEOUT (T),
    .USE_ACK     (1'b1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_we       (cmd_we),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .bus_addr     (bus_addr),
    .bus_data_out (bus_data_out),
    .bus_we       (bus_we),
    .bus_data_in  (bus_data_in),
    .bus_clk      (bus_clk),
    .bus_stb      (bus_stb),
    .bus_ack      (bus_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Completion cycle from ack timing: ack rising in cycle k is usable in k+2
  function automatic int exp_done(input int ack_at, output logic err);
    int v;
    err = 1'b1;
    if (ack_at == 0) return 3*D + T + 1;
    v = ack_at + 2;
    err = 1'b0;
    if (v <= 3*D) return 3*D + 1;
    if (v <= 3*D + T) return v + 1;
    err = 1'b1;
    return 3*D + T + 1;
  endfunction

  // One transaction; ack_at = cycle the raw ack rises (0 = never)
  task automatic run_txn(input logic we, input logic [1:0] addr, input logic [7:0] wdata,
                         input logic [7:0] rdat, input int ack_at, input string tag);
    int         done;
    logic       err_e;
    logic [7:0] rdata_e;
    done    = exp_done(ack_at, err_e);
    rdata_e = we ? 8'h00 : rdat;
    @(negedge clk);
    check({tag, ".ready_pre"}, cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_we    = 1'($urandom);
    cmd_addr  = 2'($urandom);
    cmd_wdata = 8'($urandom);
    for (int cyc = 1; cyc <= done + 1; cyc++) begin
      @(negedge clk);
      bus_ack     = (ack_at != 0) && (cyc >= ack_at);
      bus_data_in = (cyc >= D + 1 && cyc <= 2*D) ? rdat : ~rdat;
      check({tag, ".stb"},   bus_stb,   cyc < done);
      check({tag, ".bclk"},  bus_clk,   cyc >= D + 1 && cyc <= 2*D);
      check({tag, ".we"},    bus_we,    (cyc < done) ? we : 1'b0);
      check({tag, ".rvld"},  rsp_valid, cyc == done);
      check({tag, ".ready"}, cmd_ready, cyc == done + 1);
      if (cyc < done) begin
        check({tag, ".addr"}, bus_addr, addr);
        check({tag, ".dout"}, bus_data_out, we ? wdata : 8'h00);
      end
      if (cyc == done) begin
        check({tag, ".rdata"}, rsp_rdata, rdata_e);
        check({tag, ".err"},   rsp_err,   err_e);
      end
    end
    bus_ack = 1'b0;
    repeat (3) @(negedge clk);
    check({tag, ".rdata_hold"}, rsp_rdata, rdata_e);
    check({tag, ".err_hold"},   rsp_err,   err_e);
    check({tag, ".rvld_idle"},  rsp_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       rw;
    logic [1:0] ra;
    logic [7:0] rwd, rrd;
    int         rack;

    reset = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 2'd0; cmd_wdata = 8'd0;
    bus_ack = 1'b0; bus_data_in = 8'd0;
    repeat (3) @(negedge clk);
    check("rst.ready",  cmd_ready, 0);
    check("rst.stb",    bus_stb, 0);
    check("rst.bclk",   bus_clk, 0);
    check("rst.we",     bus_we, 0);
    check("rst.addr",   bus_addr, 0);
    check("rst.dout",   bus_data_out, 0);
    check("rst.rvld",   rsp_valid, 0);
    check("rst.rdata",  rsp_rdata, 0);
    check("rst.err",    rsp_err, 0);
    reset = 1'b0;
    @(negedge clk);
    check("rst.ready_after", cmd_ready, 1);

    run_txn(1'b1, 2'd0, 8'h41, 8'h00, 5,  "wr_early");
    run_txn(1'b0, 2'd1, 8'h00, 8'h5A, 5,  "rd_early");
    run_txn(1'b1, 2'd3, 8'h12, 8'h00, 0,  "no_ack");
    run_txn(1'b0, 2'd2, 8'h00, 8'hC3, 18, "late_ack");
    run_txn(1'b0, 2'd0, 8'h00, 8'h96, 10, "ack_last_hold");
    run_txn(1'b1, 2'd1, 8'h7E, 8'h00, 26, "ack_last_wait");

    // Busy then back-to-back: valid held, fields swapped right after accept
    @(negedge clk);
    bus_ack = 1'b1; bus_data_in = 8'h77;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 2'd2; cmd_wdata = 8'hA5;
    @(posedge clk);
    #1;
    cmd_we = 1'b0; cmd_addr = 2'd3; cmd_wdata = 8'h3C;
    for (int cyc = 1; cyc <= 28; cyc++) begin
      @(negedge clk);
      if (cyc == 15) cmd_valid = 1'b0;
      check("b2b.stb",   bus_stb,   (cyc <= 12) || (cyc >= 15 && cyc <= 26));
      check("b2b.bclk",  bus_clk,   (cyc >= 5 && cyc <= 8) || (cyc >= 19 && cyc <= 22));
      check("b2b.rvld",  rsp_valid, cyc == 13 || cyc == 27);
      check("b2b.ready", cmd_ready, cyc == 14 || cyc == 28);
      if (cyc <= 12) begin
        check("b2b.addr1", bus_addr, 2'd2);
        check("b2b.we1",   bus_we, 1);
        check("b2b.dout1", bus_data_out, 8'hA5);
      end
      if (cyc >= 15 && cyc <= 26) begin
        check("b2b.addr2", bus_addr, 2'd3);
        check("b2b.we2",   bus_we, 0);
        check("b2b.dout2", bus_data_out, 8'h00);
      end
      if (cyc == 13) check("b2b.rdata1", rsp_rdata, 8'h00);
      if (cyc == 27) begin
        check("b2b.rdata2", rsp_rdata, 8'h77);
        check("b2b.err2",   rsp_err, 0);
      end
    end
    bus_ack = 1'b0;
    repeat (3) @(negedge clk);

    // Leave a sticky error so the reset clearing it is visible
    run_txn(1'b1, 2'd0, 8'h01, 8'h00, 0, "pre_rst_to");

    // Reset pulsed during HIGH
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 2'd1; cmd_wdata = 8'h99;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (cyc <= 6) begin
        check("mrst.stb_pre",  bus_stb, 1);
        check("mrst.bclk_pre", bus_clk, cyc >= 5);
      end
      if (cyc == 6) reset = 1'b1;
      if (cyc == 7) begin
        check("mrst.stb",   bus_stb, 0);
        check("mrst.bclk",  bus_clk, 0);
        check("mrst.we",    bus_we, 0);
        check("mrst.addr",  bus_addr, 0);
        check("mrst.ready", cmd_ready, 0);
        reset = 1'b0;
      end
      if (cyc >= 7) check("mrst.rvld", rsp_valid, 0);
      if (cyc >= 8) begin
        check("mrst.ready_after", cmd_ready, 1);
        check("mrst.stb_after",   bus_stb, 0);
        check("mrst.err_clr",     rsp_err, 0);
      end
    end

    // Randomized commands against the schedule model
    for (int n = 0; n < 20; n++) begin
      rw  = 1'($urandom);
      ra  = 2'($urandom);
      rwd = 8'($urandom);
      rrd = 8'($urandom);
      rack = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 32));
      run_txn(rw, ra, rwd, rrd, rack, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
